// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory data-port arbiter: FSM state encoding,
// default hold limit and a small helper mapping a requester index to its
// ownership state.
package mem_port_arbiter_pkg;

    // Arbiter ownership states. Encoding is fixed so debug tooling can
    // decode the exposed state value without this package.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    // Default number of consecutive grants one owner may take while the
    // other requester is waiting.
    localparam int MAX_HOLD_DEFAULT = 8;

    // Ownership state for a given requester index.
    function automatic arb_state_t owner_state(input logic idx);
        return idx ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_select.sv
// Two-input round-robin picker. When both requesters are active the one
// named by rr_ptr wins; otherwise the single active requester wins.
// pick=0 selects requester 0, pick=1 selects requester 1. any flags that at
// least one requester is active (pick is meaningless when any=0).
module rr_select (
    input  logic req0,
    input  logic req1,
    input  logic rr_ptr,
    output logic pick,
    output logic any
);

    // Tie goes to rr_ptr; a lone request wins outright.
    always_comb begin
        any  = req0 | req1;
        pick = 1'b0;
        if (req0 && req1) begin
            pick = rr_ptr;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single data port of Memory (A2/RD2, A3/WD3/WE3)
// between the CORE load/store path (requester 0) and a debug/loader master
// (requester 1).
//
// Handshake (both requesters): a requester raises reqk and holds
// addrk/wek/wdatak stable while reqk=1. Every cycle in which gntk=1 is one
// completed transfer: a write commits at the clock edge ending that cycle,
// a read captures mem_rd into rdatak at that edge and rvalidk is high for
// exactly the following cycle. gntk is combinational from the owner state
// and reqk, so dropping reqk withdraws the grant in the same cycle.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,

    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,

    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd,

    output logic [1:0]    dbg_state,
    output logic          dbg_rr_ptr
);

    // Counter is wide enough to hold MAX_HOLD-1; at least one bit so the
    // MAX_HOLD=1 configuration (switch after every grant) still elaborates.
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD - 1);

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic [HW-1:0] hold_cnt_q;
    logic          rr_ptr_q;
    logic          pick;
    logic          any_req;
    logic          hold_limit;
    logic          granted;
    logic          rd_take0;
    logic          rd_take1;

    rr_select u_rr_select (
        .req0   (req0),
        .req1   (req1),
        .rr_ptr (rr_ptr_q),
        .pick   (pick),
        .any    (any_req)
    );

    assign hold_limit = (hold_cnt_q == HOLD_LIMIT);
    assign granted    = gnt0 | gnt1;
    assign rd_take0   = gnt0 & ~we0;
    assign rd_take1   = gnt1 & ~we1;
    assign dbg_state  = state_q;
    assign dbg_rr_ptr = rr_ptr_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: claim from IDLE, release on request drop, forced hand-over
    // when the owner has used up its hold budget and the other side waits.
    // A request drop coinciding with the hold limit is simply a release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = owner_state(pick);
                end
            end
            ST_OWN0: begin
                if (!req0) begin
                    state_d = req1 ? ST_OWN1 : ST_IDLE;
                end else if (hold_limit && req1) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN1: begin
                if (!req1) begin
                    state_d = req0 ? ST_OWN0 : ST_IDLE;
                end else if (hold_limit && req0) begin
                    state_d = ST_OWN0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: grant and port mux follow the current owner; reset kills any
    // write strobe immediately so an in-flight write never commits.
    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        mem_we = 1'b0;
        case (state_q)
            ST_OWN0: begin
                gnt0   = req0;
                mem_a  = addr0;
                mem_wd = wdata0;
                mem_we = req0 & we0;
            end
            ST_OWN1: begin
                gnt1   = req1;
                mem_a  = addr1;
                mem_wd = wdata1;
                mem_we = req1 & we1;
            end
            default: begin
                gnt0   = 1'b0;
                gnt1   = 1'b0;
            end
        endcase
        if (reset) begin
            gnt0   = 1'b0;
            gnt1   = 1'b0;
            mem_we = 1'b0;
        end
    end

    // Hold counter and round-robin pointer: count the owner's grants
    // (saturating), restart on any ownership change, and hand the next tie
    // to whoever did not just own the port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt_q <= '0;
            rr_ptr_q   <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                hold_cnt_q <= '0;
            end else if (granted && !hold_limit) begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
            end
            if (state_q == ST_OWN0 && state_d != ST_OWN0) begin
                rr_ptr_q <= 1'b1;
            end else if (state_q == ST_OWN1 && state_d != ST_OWN1) begin
                rr_ptr_q <= 1'b0;
            end
        end
    end

    // Read return: capture memory data at the end of a granted read and
    // flag it valid for exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= rd_take0;
            rvalid1 <= rd_take1;
            if (rd_take0) begin
                rdata0 <= mem_rd;
            end
            if (rd_take1) begin
                rdata1 <= mem_rd;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: one instance with the default hold limit
// and one with MAX_HOLD=1, each with its own word-addressed memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_init;

    // Instance A (MAX_HOLD=8)
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, rvalid0, gnt1, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;
    logic [1:0]  dbg_state;
    logic        dbg_rr_ptr;

    // Instance B (MAX_HOLD=1)
    logic        b_req0, b_we0, b_req1, b_we1;
    logic [31:0] b_addr0, b_wdata0, b_addr1, b_wdata1;
    logic        b_gnt0, b_rvalid0, b_gnt1, b_rvalid1;
    logic [31:0] b_rdata0, b_rdata1;
    logic [31:0] b_mem_a, b_mem_wd, b_mem_rd;
    logic        b_mem_we;
    logic [1:0]  b_dbg_state;
    logic        b_dbg_rr_ptr;

    logic [31:0] mem_arr   [0:15];
    logic [31:0] b_mem_arr [0:15];
    logic [31:0] ref_mem   [0:15];

    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];
    logic [31:0] b_exp0_q[$];
    logic [31:0] b_exp1_q[$];

    int n_vec = 0;
    int n_err = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_HOLD(8)) dut_a (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
        .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_HOLD(1)) dut_b (
        .clk(clk), .reset(reset),
        .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0),
        .gnt0(b_gnt0), .rvalid0(b_rvalid0), .rdata0(b_rdata0),
        .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1),
        .gnt1(b_gnt1), .rvalid1(b_rvalid1), .rdata1(b_rdata1),
        .mem_a(b_mem_a), .mem_wd(b_mem_wd), .mem_we(b_mem_we), .mem_rd(b_mem_rd),
        .dbg_state(b_dbg_state), .dbg_rr_ptr(b_dbg_rr_ptr)
    );

    // Memory models: combinational read, write at the rising edge.
    assign mem_rd   = mem_arr[mem_a[5:2]];
    assign b_mem_rd = b_mem_arr[b_mem_a[5:2]];

    always @(posedge clk or posedge mem_init) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) begin
                mem_arr[i]   <= 32'h1000_0000 + 32'(i);
                b_mem_arr[i] <= 32'h1000_0000 + 32'(i);
            end
        end else begin
            if (mem_we) mem_arr[mem_a[5:2]] <= mem_wd;
            if (b_mem_we) b_mem_arr[b_mem_a[5:2]] <= b_mem_wd;
        end
    end

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        logic [31:0] e;
        if (rvalid0) begin
            n_vec++;
            if (exp0_q.size() == 0) begin
                n_err++;
                $display("FAIL a_rvalid0_unexpected: rvalid0=1 rdata0=%h, expected no read return", rdata0);
            end else begin
                e = exp0_q.pop_front();
                if (rdata0 !== e) begin
                    n_err++;
                    $display("FAIL a_rdata0: got %h expected %h", rdata0, e);
                end
            end
        end
        if (rvalid1) begin
            n_vec++;
            if (exp1_q.size() == 0) begin
                n_err++;
                $display("FAIL a_rvalid1_unexpected: rvalid1=1 rdata1=%h, expected no read return", rdata1);
            end else begin
                e = exp1_q.pop_front();
                if (rdata1 !== e) begin
                    n_err++;
                    $display("FAIL a_rdata1: got %h expected %h", rdata1, e);
                end
            end
        end
        if (b_rvalid0 && b_rvalid1) begin
            n_vec++;
            n_err++;
            $display("FAIL b_rvalid_both: rvalid0=1 rvalid1=1, expected at most one");
        end
        if (b_rvalid0) begin
            n_vec++;
            if (b_exp0_q.size() == 0) begin
                n_err++;
                $display("FAIL b_rvalid0_unexpected: rdata0=%h, expected no read return", b_rdata0);
            end else begin
                e = b_exp0_q.pop_front();
                if (b_rdata0 !== e) begin
                    n_err++;
                    $display("FAIL b_rdata0: got %h expected %h", b_rdata0, e);
                end
            end
        end
        if (b_rvalid1) begin
            n_vec++;
            if (b_exp1_q.size() == 0) begin
                n_err++;
                $display("FAIL b_rvalid1_unexpected: rdata1=%h, expected no read return", b_rdata1);
            end else begin
                e = b_exp1_q.pop_front();
                if (b_rdata1 !== e) begin
                    n_err++;
                    $display("FAIL b_rdata1: got %h expected %h", b_rdata1, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        b_req0 = 0; b_we0 = 0; b_addr0 = 0; b_wdata0 = 0;
        b_req1 = 0; b_we1 = 0; b_addr1 = 0; b_wdata1 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        tick();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        req0 = 1; we0 = 0; addr0 = 32'h0;
        #2;
        n_vec++;
        if (gnt0 !== 1'b0 || mem_we !== 1'b0 || rvalid0 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs_t0: gnt0=%b mem_we=%b rvalid0=%b expected 0 0 0", gnt0, mem_we, rvalid0);
        end
        tick();
        #2;
        n_vec++;
        if (gnt0 !== 1'b0 || mem_we !== 1'b0 || rvalid0 !== 1'b0 || mem_a !== 32'h0 || dbg_rr_ptr !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs_t1: gnt0=%b mem_we=%b rvalid0=%b mem_a=%h rr=%b expected 0 0 0 0 0",
                     gnt0, mem_we, rvalid0, mem_a, dbg_rr_ptr);
        end
        tick();
        reset = 0;
        #2;
        n_vec++;
        if (gnt0 !== 1'b0 || dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL reset_release_idle: gnt0=%b state=%0d expected 0 0", gnt0, dbg_state);
        end
        tick();
        #2;
        n_vec++;
        if (gnt0 !== 1'b1 || mem_a !== 32'h0 || mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL reset_first_grant: gnt0=%b mem_a=%h mem_we=%b expected 1 0 0", gnt0, mem_a, mem_we);
        end
        exp0_q.push_back(ref_mem[0]);
        tick();
        req0 = 0;
        tick();
        tick();
    endtask

    task automatic test_write_read();
        do_reset();
        req0 = 1; we0 = 1; addr0 = 32'd4; wdata0 = 32'h0000ABCD;
        tick();
        #2;
        n_vec++;
        if (gnt0 !== 1'b1 || mem_we !== 1'b1 || mem_a !== 32'd4 || mem_wd !== 32'h0000ABCD) begin
            n_err++;
            $display("FAIL core_write: gnt0=%b mem_we=%b mem_a=%h mem_wd=%h expected 1 1 4 0000abcd",
                     gnt0, mem_we, mem_a, mem_wd);
        end
        ref_mem[1] = 32'h0000ABCD;
        tick();
        we0 = 0;
        #2;
        n_vec++;
        if (gnt0 !== 1'b1 || mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL core_read_grant: gnt0=%b mem_we=%b expected 1 0", gnt0, mem_we);
        end
        exp0_q.push_back(ref_mem[1]);
        tick();
        req0 = 0;
        #2;
        n_vec++;
        if (rvalid0 !== 1'b1) begin
            n_err++;
            $display("FAIL core_read_rvalid: rvalid0=%b expected 1", rvalid0);
        end
        tick();
        tick();
    endtask

    task automatic test_tie_rr();
        do_reset();
        req0 = 1; we0 = 0; addr0 = 32'd0;
        req1 = 1; we1 = 0; addr1 = 32'd4;
        tick();
        #2;
        n_vec++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            n_err++;
            $display("FAIL tie_first_own0: gnt0=%b gnt1=%b expected 1 0", gnt0, gnt1);
        end
        exp0_q.push_back(ref_mem[0]);
        tick();
        req0 = 0;
        #2;
        n_vec++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            n_err++;
            $display("FAIL tie_drop_cycle: gnt0=%b gnt1=%b expected 0 0", gnt0, gnt1);
        end
        tick();
        #2;
        n_vec++;
        if (gnt1 !== 1'b1 || mem_a !== 32'd4) begin
            n_err++;
            $display("FAIL tie_handover_no_bubble: gnt1=%b mem_a=%h expected 1 4", gnt1, mem_a);
        end
        exp1_q.push_back(ref_mem[1]);
        tick();
        req1 = 0;
        tick();
        #2;
        n_vec++;
        if (dbg_rr_ptr !== 1'b0 || dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL tie_rr_after_own1: rr_ptr=%b state=%0d expected 0 0", dbg_rr_ptr, dbg_state);
        end
        req0 = 1;
        req1 = 1;
        tick();
        #2;
        n_vec++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            n_err++;
            $display("FAIL tie_second_own0: gnt0=%b gnt1=%b expected 1 0", gnt0, gnt1);
        end
        exp0_q.push_back(ref_mem[0]);
        tick();
        req0 = 0;
        req1 = 0;
        tick();
        tick();
    endtask

    task automatic test_starvation();
        logic eg0, eg1;
        do_reset();
        req1 = 1; we1 = 0; addr1 = 32'd8;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 2) begin
                req0 = 1; we0 = 0; addr0 = 32'd0;
            end
            #2;
            eg1 = (i <= 8);
            eg0 = (i == 9);
            n_vec++;
            if (gnt1 !== eg1 || gnt0 !== eg0) begin
                n_err++;
                $display("FAIL starve_cycle%0d: gnt0=%b gnt1=%b expected %b %b", i, gnt0, gnt1, eg0, eg1);
            end
            if (eg1) exp1_q.push_back(ref_mem[2]);
            if (eg0) exp0_q.push_back(ref_mem[0]);
        end
        tick();
        req0 = 0;
        for (int i = 0; i < 13; i++) begin
            tick();
            #2;
            n_vec++;
            if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
                n_err++;
                $display("FAIL starve_saturate%0d: gnt0=%b gnt1=%b expected 0 1", i, gnt0, gnt1);
            end
            exp1_q.push_back(ref_mem[2]);
        end
        tick();
        req1 = 0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        req1 = 1; we1 = 1; addr1 = 32'd8; wdata1 = 32'h0000DEAD;
        tick();
        #2;
        n_vec++;
        if (gnt1 !== 1'b1 || mem_we !== 1'b1) begin
            n_err++;
            $display("FAIL midwrite_grant: gnt1=%b mem_we=%b expected 1 1", gnt1, mem_we);
        end
        reset = 1;
        #1;
        n_vec++;
        if (mem_we !== 1'b0 || gnt1 !== 1'b0) begin
            n_err++;
            $display("FAIL midwrite_async_drop: mem_we=%b gnt1=%b expected 0 0", mem_we, gnt1);
        end
        tick();
        req1 = 0;
        tick();
        reset = 0;
        #2;
        n_vec++;
        if (mem_arr[2] !== ref_mem[2]) begin
            n_err++;
            $display("FAIL midwrite_mem_kept: mem[8]=%h expected %h", mem_arr[2], ref_mem[2]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic eg0;
        do_reset();
        b_req0 = 1; b_we0 = 0; b_addr0 = 32'd0;
        b_req1 = 1; b_we1 = 0; b_addr1 = 32'd4;
        for (int i = 1; i <= 10; i++) begin
            tick();
            #2;
            eg0 = i[0];
            n_vec++;
            if (b_gnt0 !== eg0 || b_gnt1 !== ~eg0) begin
                n_err++;
                $display("FAIL interleave_cycle%0d: gnt0=%b gnt1=%b expected %b %b", i, b_gnt0, b_gnt1, eg0, ~eg0);
            end
            if (eg0) b_exp0_q.push_back(32'h1000_0000);
            else     b_exp1_q.push_back(32'h1000_0001);
        end
        tick();
        b_req0 = 0;
        b_req1 = 0;
        tick();
        tick();
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        reset    = 1;
        mem_init = 1;
        idle_inputs();
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);
        #1;
        mem_init = 0;

        test_reset();
        test_write_read();
        test_tie_rr();
        test_starvation();
        test_reset_mid_write();
        test_back_to_back();

        tick();
        n_vec++;
        if (exp0_q.size() != 0 || exp1_q.size() != 0 || b_exp0_q.size() != 0 || b_exp1_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: pending a0=%0d a1=%0d b0=%0d b1=%0d expected all 0",
                     exp0_q.size(), exp1_q.size(), b_exp0_q.size(), b_exp1_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
